// File: rtl/err_acc_bank_pkg.sv
// Shared definitions for the multi-channel error accumulator.
//   FP_EXN_*   : FloPoCo exception codes carried in the top two bits of each value.
//   state_e    : accumulator FSM states.
//   fp_exp_w() : exponent width for a given IEEE-style float width.
package err_acc_bank_pkg;

  localparam logic [1:0] FP_EXN_ZERO   = 2'b00;
  localparam logic [1:0] FP_EXN_NORMAL = 2'b01;
  localparam logic [1:0] FP_EXN_INF    = 2'b10;
  localparam logic [1:0] FP_EXN_NAN    = 2'b11;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int unsigned fp_exp_w(input int unsigned bit_width);
    case (bit_width)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/FPAdder_nonpipe.sv
// Combinational FloPoCo-format floating-point adder, round to nearest even.
//   X, Y : operands {exn[1:0], sign, exp, frac}
//   R    : X + Y in the same format; NaN/inf pass through, no subnormals
//          (results below the exponent range flush to zero).
module FPAdder_nonpipe
  import err_acc_bank_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic [BIT_WIDTH+1:0] X,
  input  logic [BIT_WIDTH+1:0] Y,
  output logic [BIT_WIDTH+1:0] R
);

  localparam int unsigned WE = fp_exp_w(BIT_WIDTH);
  localparam int unsigned WF = BIT_WIDTH - 1 - WE;
  // Significand with hidden bit plus guard, round and sticky bits.
  localparam int unsigned MW = WF + 4;

  logic [1:0]    xn, yn;
  logic          xs, ys, sa, sb, swap;
  logic [WE-1:0] xe, ye, ae, be, d;
  logic [WF-1:0] xf, yf, af, bf, frac;
  logic [MW-1:0] ma, mb, mb_sh, lost, norm;
  logic [MW:0]   sum;
  logic [WF+1:0] mant;
  logic          rnd_up, found;
  logic [BIT_WIDTH+1:0] norm_r;
  int            lz, e_res;

  assign {xn, xs, xe, xf} = X;
  assign {yn, ys, ye, yf} = Y;

  // Larger magnitude goes in the 'a' lane so the subtraction never goes negative.
  assign swap         = {ye, yf} > {xe, xf};
  assign {sa, ae, af} = swap ? {ys, ye, yf} : {xs, xe, xf};
  assign {sb, be, bf} = swap ? {xs, xe, xf} : {ys, ye, yf};

  always_comb begin
    d  = ae - be;
    ma = {1'b1, af, 3'b000};
    mb = {1'b1, bf, 3'b000};
    if (int'(d) >= int'(MW)) begin
      mb_sh = '0;
      lost  = mb;
    end else begin
      mb_sh = mb >> d;
      lost  = mb & ~({MW{1'b1}} << d);
    end
    mb_sh[0] = mb_sh[0] | (|lost);
    sum = (sa ^ sb) ? ({1'b0, ma} - {1'b0, mb_sh}) : ({1'b0, ma} + {1'b0, mb_sh});

    lz    = 0;
    found = 1'b0;
    for (int i = int'(MW) - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 1;
      end
    end

    if (sum[MW]) begin
      norm  = {sum[MW:2], sum[1] | sum[0]};
      e_res = int'(ae) + 1;
    end else begin
      norm  = sum[MW-1:0] << lz;
      e_res = int'(ae) - lz;
    end

    rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant   = {1'b0, norm[MW-1:3]} + {{(WF+1){1'b0}}, rnd_up};
    if (mant[WF+1]) e_res = e_res + 1;
    frac = mant[WF+1] ? mant[WF:1] : mant[WF-1:0];

    norm_r = {FP_EXN_NORMAL, sa, e_res[WE-1:0], frac};
    if (sum == '0) begin
      norm_r = '0;
    end else if (e_res > (2 ** WE) - 1) begin
      norm_r = {FP_EXN_INF, sa, {(BIT_WIDTH-1){1'b0}}};
    end else if (e_res < 0) begin
      norm_r = {FP_EXN_ZERO, sa, {(BIT_WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    R = norm_r;
    if (xn == FP_EXN_NAN || yn == FP_EXN_NAN ||
        (xn == FP_EXN_INF && yn == FP_EXN_INF && xs != ys)) begin
      R = '0;
      R[BIT_WIDTH+1:BIT_WIDTH] = FP_EXN_NAN;
    end else if (xn == FP_EXN_INF) begin
      R = X;
    end else if (yn == FP_EXN_INF) begin
      R = Y;
    end else if (xn == FP_EXN_ZERO && yn == FP_EXN_ZERO) begin
      R = {FP_EXN_ZERO, xs & ys, {(BIT_WIDTH-1){1'b0}}};
    end else if (xn == FP_EXN_ZERO) begin
      R = Y;
    end else if (yn == FP_EXN_ZERO) begin
      R = X;
    end
  end

endmodule

// File: rtl/err_acc_bank.sv
// Multi-channel error accumulator: sums one FloPoCo error value per channel per
// sample over a batch, then drains the per-channel sums with the sample count.
//   CLK, RESET            : clock, synchronous active-high reset
//   IN_DATA/VALID/READY   : error stream, channel order 0..N_CH-1 repeating
//   FLUSH                 : end the batch at the next sample boundary
//   OUT_DATA/CH/COUNT     : drained sum, its channel, samples in the batch
//   OUT_VALID/READY       : drain handshake
// EXTRA_BITS must be 0 or 2.
module err_acc_bank
  import err_acc_bank_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned EXTRA_BITS = 2,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned BATCH      = 8,
  parameter int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int unsigned CNT_W      = $clog2(BATCH + 1)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] IN_DATA,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic                            FLUSH,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0] OUT_DATA,
  output logic [CH_W-1:0]                 OUT_CH,
  output logic [CNT_W-1:0]                OUT_COUNT,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY
);

  localparam int unsigned FW = BIT_WIDTH + 2;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   in_ch_q, in_ch_d, rd_ch_q, rd_ch_d;
  logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [FW-1:0]     acc_q [N_CH];
  logic [FW-1:0]     in_ext, rhs, sum, out_full;
  logic              in_hs, last_in, last_rd;

  if (EXTRA_BITS == 0) begin : g_no_exn
    assign in_ext   = {FP_EXN_NORMAL, IN_DATA};
    assign OUT_DATA = out_full[BIT_WIDTH-1:0];
  end else begin : g_exn
    assign in_ext   = IN_DATA;
    assign OUT_DATA = out_full;
  end

  assign IN_READY = (state_q == ST_ACCUM);
  assign in_hs    = IN_VALID & IN_READY;
  assign last_in  = (in_ch_q == CH_W'(N_CH - 1));
  assign last_rd  = (rd_ch_q == CH_W'(N_CH - 1));

  // First sample of a batch adds to zero so old sums never need clearing.
  assign rhs = (smp_cnt_q != '0) ? acc_q[in_ch_q] : '0;

  FPAdder_nonpipe #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_add (
    .X(in_ext),
    .Y(rhs),
    .R(sum)
  );

  always_comb begin
    state_d      = state_q;
    in_ch_d      = in_ch_q;
    rd_ch_d      = rd_ch_q;
    smp_cnt_d    = smp_cnt_q;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (in_hs) begin
          if (last_in) begin
            in_ch_d   = '0;
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
          end else begin
            in_ch_d = in_ch_q + CH_W'(1);
          end
        end
        // FLUSH is judged against the position after this cycle's beat: a
        // sample still in progress defers the drain to its last beat.
        if (FLUSH) begin
          if (in_ch_d != '0)        flush_pend_d = 1'b1;
          else if (smp_cnt_d != '0) state_d = ST_DRAIN;
        end
        if (in_hs && last_in && (smp_cnt_d == CNT_W'(BATCH) || flush_pend_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (OUT_READY) begin
          if (last_rd) begin
            state_d      = ST_ACCUM;
            rd_ch_d      = '0;
            smp_cnt_d    = '0;
            flush_pend_d = 1'b0;
          end else begin
            rd_ch_d = rd_ch_q + CH_W'(1);
          end
        end
      end
    endcase
  end

  assign OUT_VALID = (state_q == ST_DRAIN);
  assign out_full  = OUT_VALID ? acc_q[rd_ch_q] : '0;
  assign OUT_CH    = OUT_VALID ? rd_ch_q : '0;
  assign OUT_COUNT = OUT_VALID ? smp_cnt_q : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_ACCUM;
      in_ch_q      <= '0;
      rd_ch_q      <= '0;
      smp_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) acc_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      in_ch_q      <= in_ch_d;
      rd_ch_q      <= rd_ch_d;
      smp_cnt_q    <= smp_cnt_d;
      flush_pend_q <= flush_pend_d;
      if (in_hs) acc_q[in_ch_q] <= sum;
    end
  end

endmodule

// File: tb/tb_err_acc_bank.sv
// Directed bench for err_acc_bank: two channels, batch of two, plus a second
// instance built without exception bits on the ports.
module tb_err_acc_bank;

  localparam logic [33:0] F1 = 34'h1_3F800000;
  localparam logic [33:0] F2 = 34'h1_40000000;
  localparam logic [33:0] F3 = 34'h1_40400000;
  localparam logic [33:0] F4 = 34'h1_40800000;
  localparam logic [33:0] F6 = 34'h1_40C00000;
  localparam logic [33:0] F9 = 34'h1_41100000;

  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] in_data;
  logic        in_valid, in_ready, flush;
  logic [33:0] out_data;
  logic [0:0]  out_ch;
  logic [1:0]  out_count;
  logic        out_valid, out_ready;

  logic [31:0] in0_data;
  logic        in0_valid, in0_ready, flush0, out0_ready;
  logic [31:0] out0_data;
  logic [0:0]  out0_ch;
  logic [1:0]  out0_count;
  logic        out0_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  err_acc_bank #(
    .BIT_WIDTH(32), .EXTRA_BITS(2), .N_CH(2), .BATCH(2)
  ) dut (
    .CLK(clk), .RESET(reset), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .FLUSH(flush), .OUT_DATA(out_data), .OUT_CH(out_ch), .OUT_COUNT(out_count),
    .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  err_acc_bank #(
    .BIT_WIDTH(32), .EXTRA_BITS(0), .N_CH(2), .BATCH(2)
  ) dut0 (
    .CLK(clk), .RESET(reset), .IN_DATA(in0_data), .IN_VALID(in0_valid), .IN_READY(in0_ready),
    .FLUSH(flush0), .OUT_DATA(out0_data), .OUT_CH(out0_ch), .OUT_COUNT(out0_count),
    .OUT_VALID(out0_valid), .OUT_READY(out0_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Presents one beat at a negedge; it is taken at the following posedge.
  task automatic send(input logic [33:0] data, input logic fl);
    check_eq("send_ready", 64'(in_ready), 64'd1);
    in_data  = data;
    in_valid = 1'b1;
    flush    = fl;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [0:0] ch, input logic [33:0] data,
                            input logic [1:0] cnt);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_ch"}, 64'(out_ch), 64'(ch));
    check_eq({tag, "_data"}, 64'(out_data), 64'(data));
    check_eq({tag, "_count"}, 64'(out_count), 64'(cnt));
    check_eq({tag, "_inrdy"}, 64'(in_ready), 64'd0);
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_inrdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic send0(input logic [31:0] data);
    in0_data  = data;
    in0_valid = 1'b1;
    @(negedge clk);
    in0_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    in0_data   = '0;
    in0_valid  = 1'b0;
    flush0     = 1'b0;
    out0_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    expect_idle("rst");
    check_eq("rst_data", 64'(out_data), 64'd0);
    check_eq("rst_ch", 64'(out_ch), 64'd0);
    check_eq("rst_count", 64'(out_count), 64'd0);

    // Nominal batch with backpressure; an offered beat during drain is ignored
    send(F1, 1'b0);
    send(F2, 1'b0);
    send(F3, 1'b0);
    send(F4, 1'b0);
    in_data  = F9;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_valid", 64'(out_valid), 64'd1);
      check_eq("bp_ch", 64'(out_ch), 64'd0);
      check_eq("bp_data", 64'(out_data), 64'(F4));
      check_eq("bp_count", 64'(out_count), 64'd2);
      check_eq("bp_inrdy", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    expect_out("nom0", 1'b0, F4, 2'd2);
    expect_out("nom1", 1'b1, F6, 2'd2);
    in_valid = 1'b0;
    expect_idle("nom_end");

    // Fresh batch, no carry-over
    repeat (4) send(F1, 1'b0);
    expect_out("fresh0", 1'b0, F2, 2'd2);
    expect_out("fresh1", 1'b1, F2, 2'd2);
    expect_idle("fresh_end");

    // FLUSH mid-sample becomes pending until the sample completes
    send(F1, 1'b1);
    send(F2, 1'b0);
    expect_out("fpend0", 1'b0, F1, 2'd1);
    expect_out("fpend1", 1'b1, F2, 2'd1);
    expect_idle("fpend_end");

    // FLUSH at a sample boundary with one sample summed drains next cycle
    send(F3, 1'b0);
    send(F4, 1'b0);
    expect_idle("fbound_pre");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    expect_out("fbound0", 1'b0, F3, 2'd1);
    expect_out("fbound1", 1'b1, F4, 2'd1);

    // FLUSH with nothing accumulated is ignored
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_idle("fidle");
      @(negedge clk);
    end

    // Reset mid-drain discards the batch
    send(F1, 1'b0);
    send(F2, 1'b0);
    send(F3, 1'b0);
    send(F4, 1'b0);
    check_eq("rd_pre_ch", 64'(out_ch), 64'd0);
    check_eq("rd_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_idle("rd_post");
    reset = 1'b0;
    repeat (4) send(F1, 1'b0);
    expect_out("rd_next0", 1'b0, F2, 2'd2);
    expect_out("rd_next1", 1'b1, F2, 2'd2);

    // Build without exception bits on the ports
    repeat (4) send0(32'h3F800000);
    check_eq("nx0_valid", 64'(out0_valid), 64'd1);
    check_eq("nx0_ch", 64'(out0_ch), 64'd0);
    check_eq("nx0_data", 64'(out0_data), 64'h40000000);
    check_eq("nx0_count", 64'(out0_count), 64'd2);
    @(negedge clk);
    check_eq("nx1_ch", 64'(out0_ch), 64'd1);
    check_eq("nx1_data", 64'(out0_data), 64'h40000000);
    @(negedge clk);
    check_eq("nx_end_valid", 64'(out0_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
